compress_mc: RTL

Multi-channel, pipelined linear-to-G.711 compressor, the parametrised successor to the single-channel COMPRESS stage of the MCAC datapath. Accepts 14-bit two's-complement linear samples tagged with a channel number and returns the 8-bit companded code. The law (µ-law or A-law) and the enable state are programmable per channel. Valid/ready handshakes on both sides allow time-multiplexed codec channels to share one instance, with backpressure from the PCM output formatter.

---
 rtl/compress_mc_if.sv | 25 ++
 rtl/compress_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/compress_mc_if.sv
// Sample stream interface for compress_mc: linear samples in, G.711 codes out.
// The slave modport is the compressor; the master modport is whoever feeds it
// samples and drains its codes.
interface compress_mc_if #(
  parameter int CH_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [13:0]     in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [7:0]      out_code;

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_code
  );

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_code
  );
endinterface

// File: rtl/compress_mc.sv
// Multi-channel pipelined linear-to-G.711 compressor.
// Per-channel law/enable registers; four register stages:
//   1: input capture (sample, channel, law)
//   2: magnitude, bias and clip
//   3: segment priority encode
//   4: mantissa select and final XOR into the output register
// Dropped samples travel as bubbles. The whole pipe shifts on advance, and
// out_valid & ~out_ready freezes every stage.
module compress_mc #(
  parameter int   CHANNELS    = 4,
  parameter int   CH_W        = 2,
  parameter logic DEFAULT_LAW = 1'b0,
  parameter int   DROP_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic              scan_in0,
  output logic              scan_out0,
  compress_mc_if.slave      bus,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_law,
  input  logic              cfg_en,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int STAGES = 4;

  // Index of the most significant set bit (0 when v is zero).
  function automatic logic [3:0] msb13(input logic [12:0] v);
    msb13 = 4'd0;
    for (int i = 0; i < 13; i++)
      if (v[i]) msb13 = 4'(i);
  endfunction

  // Scan pins are stitched at scan insertion; nothing to do in RTL.
  logic unused_scan;
  assign unused_scan = scan_en ^ scan_in0;
  assign scan_out0   = 1'b0;

  // Config state.
  logic [CHANNELS-1:0] law_q, law_d, en_q, en_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Pipeline valid bits, one per register stage.
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;

  // Stage 1: raw input.
  logic [CH_W-1:0] s1_ch_q, s1_ch_d;
  logic            s1_law_q, s1_law_d;
  logic [13:0]     s1_x_q, s1_x_d;

  // Stage 2: biased/clipped mu-law magnitude or A-law p.
  logic [CH_W-1:0] s2_ch_q, s2_ch_d;
  logic            s2_law_q, s2_law_d;
  logic            s2_neg_q, s2_neg_d;
  logic [12:0]     s2_val_q, s2_val_d;

  // Stage 3: value plus segment.
  logic [CH_W-1:0] s3_ch_q, s3_ch_d;
  logic            s3_law_q, s3_law_d;
  logic            s3_neg_q, s3_neg_d;
  logic [12:0]     s3_val_q, s3_val_d;
  logic [2:0]      s3_seg_q, s3_seg_d;

  // Stage 4: output register.
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [7:0]      out_code_q, out_code_d;

  logic advance, accept, keep, law_sel, en_sel;

  // Handshake, per-channel lookup at acceptance, config writes and drop count.
  // law/en are read from the registered state, so a same-cycle write only
  // affects later samples.
  always_comb begin
    advance = ~vld_pipe_q[STAGES] | bus.out_ready;
    accept  = bus.in_valid & advance;
    law_sel = 1'b0;
    en_sel  = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      if (bus.in_ch == CH_W'(c)) begin
        law_sel = law_q[c];
        en_sel  = en_q[c];
      end
    keep = accept & en_sel;

    law_d = law_q;
    en_d  = en_q;
    if (cfg_we)
      for (int c = 0; c < CHANNELS; c++)
        if (cfg_ch == CH_W'(c)) begin
          law_d[c] = cfg_law;
          en_d[c]  = cfg_en;
        end

    drop_cnt_d = drop_cnt_q;
    if (accept && !en_sel && !(&drop_cnt_q))
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  logic [13:0] mag, clip;
  logic [12:0] mu_m;
  logic [11:0] a_p;
  logic [3:0]  shamt;
  logic [7:0]  xor_k;

  // Datapath for all stages; everything holds unless the pipe advances.
  always_comb begin
    // magnitude/bias/clip for mu-law, one's-complement fold of x>>>1 for A-law
    mag  = s1_x_q[13] ? (~s1_x_q + 14'd1) : s1_x_q;
    clip = (mag > 14'd8158) ? 14'd8158 : mag;
    mu_m = clip[12:0] + 13'd33;
    a_p  = s1_x_q[13] ? ~s1_x_q[12:1] : s1_x_q[12:1];

    // mantissa shift: seg+1 for mu-law, 1 for low A-law segments, else seg
    if (s3_law_q) shamt = (s3_seg_q < 3'd2) ? 4'd1 : {1'b0, s3_seg_q};
    else          shamt = {1'b0, s3_seg_q} + 4'd1;
    if (s3_law_q) xor_k = s3_neg_q ? 8'h55 : 8'hD5;
    else          xor_k = s3_neg_q ? 8'h7F : 8'hFF;

    vld_pipe_d = vld_pipe_q;
    s1_ch_d    = s1_ch_q;
    s1_law_d   = s1_law_q;
    s1_x_d     = s1_x_q;
    s2_ch_d    = s2_ch_q;
    s2_law_d   = s2_law_q;
    s2_neg_d   = s2_neg_q;
    s2_val_d   = s2_val_q;
    s3_ch_d    = s3_ch_q;
    s3_law_d   = s3_law_q;
    s3_neg_d   = s3_neg_q;
    s3_val_d   = s3_val_q;
    s3_seg_d   = s3_seg_q;
    out_ch_d   = out_ch_q;
    out_code_d = out_code_q;

    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], keep};

      s1_ch_d  = bus.in_ch;
      s1_law_d = law_sel;
      s1_x_d   = bus.in_data;

      s2_ch_d  = s1_ch_q;
      s2_law_d = s1_law_q;
      s2_neg_d = s1_x_q[13];
      s2_val_d = s1_law_q ? {1'b0, a_p} : mu_m;

      s3_ch_d  = s2_ch_q;
      s3_law_d = s2_law_q;
      s3_neg_d = s2_neg_q;
      s3_val_d = s2_val_q;
      if (s2_law_q)
        s3_seg_d = (s2_val_q < 13'd32) ? 3'd0 : 3'(msb13(s2_val_q) - 4'd4);
      else
        s3_seg_d = 3'(msb13(s2_val_q) - 4'd5);

      out_ch_d   = s3_ch_q;
      out_code_d = {s3_seg_q, 4'(s3_val_q >> shamt)} ^ xor_k;
    end
  end

  // All state; reset empties the pipe and restores per-channel defaults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      law_q      <= {CHANNELS{DEFAULT_LAW}};
      en_q       <= '1;
      drop_cnt_q <= '0;
      vld_pipe_q <= '0;
      s1_ch_q    <= '0;
      s1_law_q   <= 1'b0;
      s1_x_q     <= '0;
      s2_ch_q    <= '0;
      s2_law_q   <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_val_q   <= '0;
      s3_ch_q    <= '0;
      s3_law_q   <= 1'b0;
      s3_neg_q   <= 1'b0;
      s3_val_q   <= '0;
      s3_seg_q   <= '0;
      out_ch_q   <= '0;
      out_code_q <= '0;
    end else begin
      law_q      <= law_d;
      en_q       <= en_d;
      drop_cnt_q <= drop_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      s1_ch_q    <= s1_ch_d;
      s1_law_q   <= s1_law_d;
      s1_x_q     <= s1_x_d;
      s2_ch_q    <= s2_ch_d;
      s2_law_q   <= s2_law_d;
      s2_neg_q   <= s2_neg_d;
      s2_val_q   <= s2_val_d;
      s3_ch_q    <= s3_ch_d;
      s3_law_q   <= s3_law_d;
      s3_neg_q   <= s3_neg_d;
      s3_val_q   <= s3_val_d;
      s3_seg_q   <= s3_seg_d;
      out_ch_q   <= out_ch_d;
      out_code_q <= out_code_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out_ch    = out_ch_q;
  assign bus.out_code  = out_code_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
